// File: rtl/counter_pkg.sv
// Shared encodings and parameter legality check for the modulo-N counter family.
//   DIR_UP / DIR_DN      : up_dn encodings
//   MODE_WRAP / MODE_SAT : sat encodings
//   params_legal()       : WIDTH/MOD/RST_VAL legality, evaluated at elaboration
package counter_pkg;

   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DN    = 1'b0;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   localparam int unsigned WIDTH_MIN = 2;
   localparam int unsigned WIDTH_MAX = 32;

   // True when 2 <= WIDTH <= 32, 2 <= MOD <= 2**WIDTH and RST_VAL < MOD.
   function automatic bit params_legal(input int unsigned     width,
                                       input longint unsigned modulus,
                                       input longint unsigned rst_val);
      bit ok;
      ok = (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
           (modulus >= 64'd2) && (modulus <= (64'd1 << width)) &&
           (rst_val < modulus);
      return ok;
   endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-count logic for mod_updown_counter.
//   i_out          : current count
//   i_up_dn        : direction (DIR_UP / DIR_DN)
//   i_sat          : mode (MODE_WRAP / MODE_SAT)
//   o_next_c       : count to take on an enabled edge
//   o_at_bound_c   : count sits at the bound in the current direction
//   o_wrap_evt_c   : enabled edge would wrap
//   o_sat_evt_c    : enabled edge would be blocked by saturation
module mod_counter_next
   import counter_pkg::*;
#(
   parameter int unsigned     WIDTH = 4,
   parameter longint unsigned MOD   = 16
) (
   input  logic [WIDTH-1:0] i_out,
   input  logic             i_up_dn,
   input  logic             i_sat,
   output logic [WIDTH-1:0] o_next_c,
   output logic             o_at_bound_c,
   output logic             o_wrap_evt_c,
   output logic             o_sat_evt_c
);

   localparam int unsigned    EW      = WIDTH + 1;
   // The modulus may equal 2**WIDTH, so it is held one bit wider than the count.
   localparam logic [WIDTH:0] MOD_EXT = EW'(MOD);
   localparam logic [WIDTH:0] MAX_EXT = EW'(MOD - 64'd1);

   logic [WIDTH:0] w_inc;
   logic [WIDTH:0] w_dec;
   logic           w_bound_up;
   logic           w_bound_dn;

   // Extended-width steps: an up step reaching MOD or a down step borrowing marks the bound.
   always_comb begin
      w_inc      = {1'b0, i_out} + EW'(1);
      w_dec      = {1'b0, i_out} - EW'(1);
      w_bound_up = (w_inc == MOD_EXT);
      w_bound_dn = w_dec[WIDTH];
   end

   always_comb begin
      o_next_c     = i_out;
      o_at_bound_c = (i_up_dn == DIR_UP) ? w_bound_up : w_bound_dn;
      o_wrap_evt_c = o_at_bound_c && (i_sat == MODE_WRAP);
      o_sat_evt_c  = o_at_bound_c && (i_sat == MODE_SAT);
      if (!o_at_bound_c) begin
         o_next_c = (i_up_dn == DIR_UP) ? w_inc[WIDTH-1:0] : w_dec[WIDTH-1:0];
      end else if (i_sat == MODE_WRAP) begin
         o_next_c = (i_up_dn == DIR_UP) ? '0 : MAX_EXT[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised modulo-MOD up/down counter with load, clear and wrap/saturate mode.
//   clk, rstn        : clock, asynchronous active-low reset
//   clr              : synchronous clear (highest priority)
//   load, load_val   : synchronous parallel load, clamped to MOD-1
//   en, up_dn, sat   : count enable, direction, saturate mode
//   out              : registered count, always < MOD
//   tc               : combinational terminal count, for cascading into the next stage's en
//   wrap             : registered one-cycle pulse on a wrapping step
//   ovf              : sticky flag, set by any wrap or blocked saturating step
module mod_updown_counter
   import counter_pkg::*;
#(
   parameter int unsigned     WIDTH   = 4,
   parameter longint unsigned MOD     = 16,
   parameter longint unsigned RST_VAL = 0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up_dn,
   input  logic             sat,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             wrap,
   output logic             ovf
);

   if (!params_legal(WIDTH, MOD, RST_VAL)) begin : g_bad_params
      $error("mod_updown_counter: illegal WIDTH/MOD/RST_VAL combination");
   end

   localparam int unsigned    EW      = WIDTH + 1;
   localparam logic [WIDTH:0] MOD_EXT = EW'(MOD);
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 64'd1);
   localparam logic [WIDTH-1:0] RST_OUT = WIDTH'(RST_VAL);

   logic [WIDTH-1:0] r_out;
   logic             r_wrap;
   logic             r_ovf;

   logic [WIDTH-1:0] w_next;
   logic             w_at_bound;
   logic             w_wrap_evt;
   logic             w_sat_evt;
   logic [WIDTH-1:0] w_load_clamp;
   logic [WIDTH-1:0] w_out_d;
   logic             w_wrap_d;
   logic             w_ovf_d;

   mod_counter_next #(
      .WIDTH (WIDTH),
      .MOD   (MOD)
   ) u_next (
      .i_out        (r_out),
      .i_up_dn      (up_dn),
      .i_sat        (sat),
      .o_next_c     (w_next),
      .o_at_bound_c (w_at_bound),
      .o_wrap_evt_c (w_wrap_evt),
      .o_sat_evt_c  (w_sat_evt)
   );

   // Out-of-range load values clamp to the top of the count range.
   always_comb begin
      w_load_clamp = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;
   end

   // Priority mux: clr > load > en > hold.
   always_comb begin
      w_out_d  = r_out;
      w_wrap_d = 1'b0;
      w_ovf_d  = r_ovf;
      if (clr) begin
         w_out_d = '0;
         w_ovf_d = 1'b0;
      end else if (load) begin
         w_out_d = w_load_clamp;
      end else if (en) begin
         w_out_d  = w_next;
         w_wrap_d = w_wrap_evt;
         w_ovf_d  = r_ovf | w_wrap_evt | w_sat_evt;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_out  <= RST_OUT;
         r_wrap <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         r_out  <= w_out_d;
         r_wrap <= w_wrap_d;
         r_ovf  <= w_ovf_d;
      end
   end

   assign out  = r_out;
   assign wrap = r_wrap;
   assign ovf  = r_ovf;
   assign tc   = en & w_at_bound;

endmodule
